seg7_scan_decoder: RTL and testbench

Receive-side companion to the team's BCD-to-seven-segment encoder. The block observes a time-multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode enables) and reconstructs the digit values being shown. It waits until the bus has been stable for a set time, then decodes the segment pattern back to BCD and stores the result for the selected digit. It drives a per-frame completion pulse and an error pulse. The block sits beside the display driver in the digital timer, for self-check and for readback of the shown time.

---
 rtl/seg7_scan_decoder.sv | 149 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Watches a time-multiplexed, active-low seven-segment bus (SEG + AN) that is
// driven from the same clock domain, waits for the bus to settle, and turns
// each settled segment pattern back into the BCD value shown on that digit.
// Holds the last legal value per digit, pulses FRAME once every digit has
// been captured legally, and pulses ERR on any capture it cannot accept.
//
// Bus handshake: there is no valid/ready pair. A value on {AN,SEG} counts as
// presented once it has been sampled unchanged on STABLE+1 consecutive
// rising edges. It is consumed on that last edge, and it is never consumed
// again until the bus changes and settles anew.

module seg7_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [6:0]            SEG,
  input  logic [DIGITS-1:0]     AN,
  output logic [4*DIGITS-1:0]   DIGIT_OUT,
  output logic [DIGITS-1:0]     DIGIT_VALID,
  output logic                  FRAME,
  output logic                  ERR
);

  localparam int SW = DIGITS + 7;
  localparam int CW = (STABLE < 1) ? 1 : $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE - 1);

  // Stability tracking
  logic [SW-1:0]         w_bus;
  logic [SW-1:0]         r_s;
  logic [CW-1:0]         r_cnt;
  logic                  w_same;
  logic                  w_capture;

  // Decode and classification
  logic [3:0]            w_val;
  logic                  w_legal;
  logic [DIGITS-1:0]     w_an_low;
  logic                  w_no_an;
  logic                  w_one_an;
  logic                  w_good;
  logic                  w_bad;
  logic [DIGITS-1:0]     w_seen_set;
  logic                  w_frame_done;

  // Output and frame state
  logic [4*DIGITS-1:0]   r_digit_out;
  logic [DIGITS-1:0]     r_digit_valid;
  logic [DIGITS-1:0]     r_seen;
  logic                  r_frame;
  logic                  r_err;

  assign w_bus     = {AN, SEG};
  assign w_same    = (w_bus == r_s);
  // The capture edge is the one that lifts the count from STABLE-1 to STABLE,
  // so a saturated count can never produce a second capture.
  assign w_capture = w_same && (r_cnt == CNT_CAP);

  // Sample register and saturating run-length counter of unchanged samples.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_s   <= '1;
      r_cnt <= '0;
    end else begin
      r_s <= w_bus;
      if (w_same) begin
        if (r_cnt == CNT_MAX) begin
          r_cnt <= CNT_MAX;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Inverse of the encoder table; anything not in it is an illegal pattern.
  always_comb begin
    w_val   = 4'hF;
    w_legal = 1'b0;
    case (SEG)
      7'b1000000: begin w_val = 4'd0; w_legal = 1'b1; end
      7'b1111001: begin w_val = 4'd1; w_legal = 1'b1; end
      7'b0100100: begin w_val = 4'd2; w_legal = 1'b1; end
      7'b0110000: begin w_val = 4'd3; w_legal = 1'b1; end
      7'b0011001: begin w_val = 4'd4; w_legal = 1'b1; end
      7'b0010010: begin w_val = 4'd5; w_legal = 1'b1; end
      7'b0000010: begin w_val = 4'd6; w_legal = 1'b1; end
      7'b1111000: begin w_val = 4'd7; w_legal = 1'b1; end
      7'b0000000: begin w_val = 4'd8; w_legal = 1'b1; end
      7'b0010000: begin w_val = 4'd9; w_legal = 1'b1; end
      7'b1111111: begin w_val = 4'hF; w_legal = 1'b1; end
      default:    begin w_val = 4'hF; w_legal = 1'b0; end
    endcase
  end

  // Anode classification: none low is a blanking gap, exactly one low names
  // the digit, more than one low is a bus fault.
  assign w_an_low = ~AN;
  assign w_no_an  = (w_an_low == '0);
  assign w_one_an = !w_no_an && ((w_an_low & (w_an_low - DIGITS'(1))) == '0);

  assign w_good       = w_capture && w_one_an && w_legal;
  assign w_bad        = w_capture && !w_no_an && !(w_one_an && w_legal);
  assign w_seen_set   = r_seen | w_an_low;
  assign w_frame_done = w_good && (w_seen_set == '1);

  // Digit store, valid flags, frame mask and the two event pulses.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_digit_out   <= '1;
      r_digit_valid <= '0;
      r_seen        <= '0;
      r_frame       <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_frame <= w_frame_done;
      r_err   <= w_bad;
      if (w_good) begin
        // The one-hot anode mask selects the digit directly, no index needed.
        for (int i = 0; i < DIGITS; i++) begin
          if (w_an_low[i]) begin
            r_digit_out[4*i +: 4] <= w_val;
          end
        end
        r_digit_valid <= r_digit_valid | w_an_low;
        r_seen        <= w_frame_done ? '0 : w_seen_set;
      end else if (w_bad) begin
        // A bad pattern on a single digit invalidates only that digit; its
        // old value stays visible. Multiple anodes touch no digit.
        if (w_one_an) begin
          r_digit_valid <= r_digit_valid & AN;
        end
        r_seen <= '0;
      end
    end
  end

  assign DIGIT_OUT   = r_digit_out;
  assign DIGIT_VALID = r_digit_valid;
  assign FRAME       = r_frame;
  assign ERR         = r_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scan sequences plus a few random
// frames. Each bus value that should be captured pushes the expected output
// snapshot (with the cycle it is due) onto a queue; every cycle the outputs
// are compared against the snapshot due now, or against the last one.

module tb_seg7_scan_decoder;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  localparam logic [6:0] CODE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef struct packed {
    logic [31:0] cyc;
    logic        frame;
    logic        err;
    logic [15:0] dout;
    logic [3:0]  dvalid;
  } exp_t;

  // Clock and reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic [15:0] digit_out;
  logic [3:0]  digit_valid;
  logic        frame;
  logic        err;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .SEG         (seg),
    .AN          (an),
    .DIGIT_OUT   (digit_out),
    .DIGIT_VALID (digit_valid),
    .FRAME       (frame),
    .ERR         (err)
  );

  // Scoreboard state
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic        mon_en = 1'b0;
  logic [15:0] mon_dout = 16'hFFFF;
  logic [3:0]  mon_dvalid = 4'h0;

  // Reference state, advanced when stimulus is driven
  logic [15:0] mdl_dout = 16'hFFFF;
  logic [3:0]  mdl_dvalid = 4'h0;
  logic [3:0]  mdl_seen = 4'h0;
  logic [10:0] prev_bus = 11'h7FF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_cycle();
    exp_t ent;
    logic f;
    logic e;
    f = 1'b0;
    e = 1'b0;
    if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      ent = exp_q.pop_front();
      chk("missed_event", cyc, ent.cyc);
    end
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      ent        = exp_q.pop_front();
      f          = ent.frame;
      e          = ent.err;
      mon_dout   = ent.dout;
      mon_dvalid = ent.dvalid;
    end
    chk("frame", {31'd0, frame}, {31'd0, f});
    chk("err", {31'd0, err}, {31'd0, e});
    chk("dout", {16'd0, digit_out}, {16'd0, mon_dout});
    chk("dvalid", {28'd0, digit_valid}, {28'd0, mon_dvalid});
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (mon_en) check_cycle();
  endtask

  // Expected effect of one settled bus value, straight from the behaviour
  // description: blanking does nothing, one anode + known code writes, the
  // rest raise ERR.
  task automatic model_capture(input logic [3:0] a, input logic [6:0] s);
    logic [3:0] an_low;
    logic       one;
    logic       legal;
    logic [3:0] val;
    exp_t       ent;
    an_low = ~a;
    if (an_low == 4'h0) return;
    one   = ((an_low & (an_low - 4'd1)) == 4'h0);
    legal = (s == BLANK);
    val   = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (s == CODE[k]) begin
        legal = 1'b1;
        val   = 4'(k);
      end
    end
    ent.frame = 1'b0;
    ent.err   = 1'b0;
    if (one && legal) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (an_low[d]) mdl_dout[4*d +: 4] = val;
      end
      mdl_dvalid = mdl_dvalid | an_low;
      mdl_seen   = mdl_seen | an_low;
      if (mdl_seen == 4'hF) begin
        ent.frame = 1'b1;
        mdl_seen  = 4'h0;
      end
    end else begin
      ent.err = 1'b1;
      if (one) mdl_dvalid = mdl_dvalid & a;
      mdl_seen = 4'h0;
    end
    ent.cyc    = cyc + 1 + STABLE;
    ent.dout   = mdl_dout;
    ent.dvalid = mdl_dvalid;
    exp_q.push_back(ent);
  endtask

  // Driver: put a value on the bus and keep it for n cycles.
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    logic [10:0] bus;
    bus = {a, s};
    an  = a;
    seg = s;
    if (bus != prev_bus && n >= STABLE + 1) model_capture(a, s);
    prev_bus = bus;
    repeat (n) tick();
  endtask

  task automatic scan_digit(input int d, input int v, input int n);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    hold(a, CODE[v], n);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    an     = 4'hF;
    seg    = BLANK;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    mdl_dout   = 16'hFFFF;
    mdl_dvalid = 4'h0;
    mdl_seen   = 4'h0;
    mon_dout   = 16'hFFFF;
    mon_dvalid = 4'h0;
    prev_bus   = 11'h7FF;
    chk("rst_dout", {16'd0, digit_out}, 32'h0000_FFFF);
    chk("rst_dvalid", {28'd0, digit_valid}, 32'h0);
    chk("rst_frame", {31'd0, frame}, 32'h0);
    chk("rst_err", {31'd0, err}, 32'h0);
    mon_en = 1'b1;
  endtask

  initial begin
    do_reset();

    // Full scan of 1,2,3,4; FRAME lands on the 5th edge of digit 3's window.
    scan_digit(0, 1, 8);
    scan_digit(1, 2, 8);
    scan_digit(2, 3, 8);
    scan_digit(3, 4, 8);
    chk("scan_dout", {16'd0, digit_out}, 32'h0000_4321);
    chk("scan_dvalid", {28'd0, digit_valid}, 32'hF);

    // Glitch rejection: a 2-cycle '8' inside a held '1' is never captured.
    hold(4'b1110, CODE[1], 8);
    hold(4'b1110, CODE[8], 2);
    hold(4'b1110, CODE[1], 8);
    chk("glitch_dout", {16'd0, digit_out}, 32'h0000_4321);

    // Illegal pattern on digit 1, then multiple anodes, then blanking.
    hold(4'b1101, 7'b0111111, 6);
    chk("illegal_dvalid", {28'd0, digit_valid}, 32'hD);
    hold(4'b1100, CODE[5], 6);
    hold(4'b1111, BLANK, 10);
    chk("multi_dout", {16'd0, digit_out}, 32'h0000_4321);

    // Blank digit 0, then digits 1..3 complete a fresh frame.
    hold(4'b1110, BLANK, 8);
    chk("blank_dout", {16'd0, digit_out}, 32'h0000_432F);
    scan_digit(1, 5, 8);
    scan_digit(2, 6, 8);
    scan_digit(3, 7, 8);

    // Mid-frame reset: two digits, reset, then a full post-reset frame.
    scan_digit(0, 2, 8);
    scan_digit(1, 3, 8);
    do_reset();
    scan_digit(0, 9, 8);
    scan_digit(1, 0, 8);
    scan_digit(2, 8, 8);
    scan_digit(3, 7, 8);
    chk("post_rst_dout", {16'd0, digit_out}, 32'h0000_7809);

    // Random frames with short random glitches and random hold lengths.
    repeat (3) begin
      for (int d = 0; d < DIGITS; d++) begin
        int v;
        int g;
        v = $urandom_range(0, 9);
        g = $urandom_range(0, 9);
        scan_digit(d, v, $urandom_range(STABLE + 1, 10));
        hold(~(4'b0001 << d), CODE[g], $urandom_range(1, STABLE));
        scan_digit(d, v, $urandom_range(STABLE + 1, 10));
      end
      hold(4'hF, BLANK, $urandom_range(1, 6));
    end

    hold(4'hF, BLANK, 10);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
